// File: rtl/aa_tile_fetch.sv
`default_nettype none
//============================================================================
// Module   : aa_tile_fetch
// Brief    : Sprite tile-attribute fetch stage. Reads the two SCB1 words of
//            a tile (tile number LSBs, then attributes), substitutes the low
//            2 or 3 tile bits with a per-frame snapshot of the
//            auto-animation count when requested, and presents the result
//            downstream over a valid/ready handshake.
// Revision : 1.0 - initial release
//============================================================================
module aa_tile_fetch (
  input  logic        CLK,
  input  logic        RESETP,
  input  logic [2:0]  AA_COUNT,
  input  logic        AA_DISABLE,
  input  logic        FRAME_START,
  input  logic        FETCH_REQ,
  input  logic [14:0] TILE_BASE,
  output logic        FETCH_BUSY,
  output logic        VRAM_RD,
  output logic [14:0] VRAM_ADDR,
  input  logic        VRAM_ACK,
  input  logic [15:0] VRAM_DATA,
  input  logic        LINE_ABORT,
  output logic        TILE_VALID,
  input  logic        TILE_READY,
  output logic [19:0] TILE_NUM,
  output logic [7:0]  TILE_PAL,
  output logic        TILE_HFLIP,
  output logic        TILE_VFLIP
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_LO = 2'd1,
    ST_RD_HI = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Word-pair base; bit 0 is always zero so only the upper bits are kept.
  logic [14:1] r_base;
  logic [15:0] r_tile_lo;
  logic [2:0]  r_aa_snap;

  logic        r_vram_rd;
  logic [14:0] r_vram_addr;
  logic        r_fetch_busy;
  logic        r_tile_valid;
  logic [19:0] r_tile_num;
  logic [7:0]  r_tile_pal;
  logic        r_tile_hflip;
  logic        r_tile_vflip;

  logic        w_accept;
  logic        w_lo_done;
  logic        w_hi_done;
  logic [14:0] w_addr_nxt;
  logic [19:0] w_tile_raw;
  logic [19:0] w_tile_dec;
  logic        w_aa3_en;
  logic        w_aa2_en;

  // The tile base always addresses an even word, so its LSB carries no data.
  logic        w_unused;
  assign w_unused = TILE_BASE[0];

  // Next-state decode; an abort overrides every other transition and
  // swallows any request, ack or ready arriving in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_lo_done   = 1'b0;
    w_hi_done   = 1'b0;
    if (LINE_ABORT) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (FETCH_REQ) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (VRAM_ACK) begin
            w_lo_done   = 1'b1;
            w_state_nxt = ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          if (VRAM_ACK) begin
            w_hi_done   = 1'b1;
            w_state_nxt = ST_OUT;
          end
        end
        ST_OUT: begin
          if (TILE_READY) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Read address for the coming cycle: even word on accept, odd word once
  // the low word lands, otherwise hold (the address is left as-is in IDLE).
  always_comb begin
    w_addr_nxt = r_vram_addr;
    if (w_accept) begin
      w_addr_nxt = {TILE_BASE[14:1], 1'b0};
    end else if (w_lo_done) begin
      w_addr_nxt = {r_base, 1'b1};
    end
  end

  // Attribute word decode. The snapshot used is the pre-edge value, so a
  // FRAME_START coinciding with the attribute ack only affects later tiles.
  assign w_tile_raw = {VRAM_DATA[7:4], r_tile_lo};
  assign w_aa3_en   = !AA_DISABLE && VRAM_DATA[3];
  assign w_aa2_en   = !AA_DISABLE && VRAM_DATA[2];

  // Auto-animation substitution; the 3-bit mode wins over the 2-bit mode.
  always_comb begin
    w_tile_dec = w_tile_raw;
    if (w_aa3_en) begin
      w_tile_dec[2:0] = r_aa_snap;
    end else if (w_aa2_en) begin
      w_tile_dec[1:0] = r_aa_snap[1:0];
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch context: word-pair base on accept, tile number LSBs on first ack.
  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      r_base    <= '0;
      r_tile_lo <= '0;
    end else begin
      if (w_accept) begin
        r_base <= TILE_BASE[14:1];
      end
      if (w_lo_done) begin
        r_tile_lo <= VRAM_DATA;
      end
    end
  end

  // Per-frame auto-animation snapshot, loaded regardless of fetch state.
  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      r_aa_snap <= '0;
    end else if (FRAME_START) begin
      r_aa_snap <= AA_COUNT;
    end
  end

  // Registered handshake/address outputs, derived from the next state.
  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      r_vram_rd    <= 1'b0;
      r_vram_addr  <= '0;
      r_fetch_busy <= 1'b0;
      r_tile_valid <= 1'b0;
    end else begin
      r_vram_rd    <= (w_state_nxt == ST_RD_LO) || (w_state_nxt == ST_RD_HI);
      r_vram_addr  <= w_addr_nxt;
      r_fetch_busy <= (w_state_nxt != ST_IDLE);
      r_tile_valid <= (w_state_nxt == ST_OUT);
    end
  end

  // Result registers: loaded only on the attribute ack, held otherwise.
  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      r_tile_num   <= '0;
      r_tile_pal   <= '0;
      r_tile_hflip <= 1'b0;
      r_tile_vflip <= 1'b0;
    end else if (w_hi_done) begin
      r_tile_num   <= w_tile_dec;
      r_tile_pal   <= VRAM_DATA[15:8];
      r_tile_hflip <= VRAM_DATA[0];
      r_tile_vflip <= VRAM_DATA[1];
    end
  end

  assign FETCH_BUSY = r_fetch_busy;
  assign VRAM_RD    = r_vram_rd;
  assign VRAM_ADDR  = r_vram_addr;
  assign TILE_VALID = r_tile_valid;
  assign TILE_NUM   = r_tile_num;
  assign TILE_PAL   = r_tile_pal;
  assign TILE_HFLIP = r_tile_hflip;
  assign TILE_VFLIP = r_tile_vflip;

endmodule
`default_nettype wire

// File: tb/tb_aa_tile_fetch.sv
`default_nettype none
//============================================================================
// Module   : tb_aa_tile_fetch
// Brief    : Scoreboard bench for aa_tile_fetch: a driver issues fetches and
//            pushes expected results, a VRAM responder serves reads with
//            scripted wait states, and a monitor checks every presented tile.
// Revision : 1.0 - initial release
//============================================================================
module tb_aa_tile_fetch;

  logic        CLK = 1'b0;
  logic        RESETP;
  logic [2:0]  AA_COUNT;
  logic        AA_DISABLE;
  logic        FRAME_START;
  logic        FETCH_REQ;
  logic [14:0] TILE_BASE;
  logic        FETCH_BUSY;
  logic        VRAM_RD;
  logic [14:0] VRAM_ADDR;
  logic        VRAM_ACK;
  logic [15:0] VRAM_DATA;
  logic        LINE_ABORT;
  logic        TILE_VALID;
  logic        TILE_READY;
  logic [19:0] TILE_NUM;
  logic [7:0]  TILE_PAL;
  logic        TILE_HFLIP;
  logic        TILE_VFLIP;

  aa_tile_fetch dut (
    .CLK(CLK), .RESETP(RESETP), .AA_COUNT(AA_COUNT), .AA_DISABLE(AA_DISABLE),
    .FRAME_START(FRAME_START), .FETCH_REQ(FETCH_REQ), .TILE_BASE(TILE_BASE),
    .FETCH_BUSY(FETCH_BUSY), .VRAM_RD(VRAM_RD), .VRAM_ADDR(VRAM_ADDR),
    .VRAM_ACK(VRAM_ACK), .VRAM_DATA(VRAM_DATA), .LINE_ABORT(LINE_ABORT),
    .TILE_VALID(TILE_VALID), .TILE_READY(TILE_READY), .TILE_NUM(TILE_NUM),
    .TILE_PAL(TILE_PAL), .TILE_HFLIP(TILE_HFLIP), .TILE_VFLIP(TILE_VFLIP)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_fail(input string nm);
    n_checks++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Expected tile record
  typedef struct {
    logic [19:0] num;
    logic [7:0]  pal;
    logic        hf;
    logic        vf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          waitq[$];
  logic [14:0] addrq[$];
  logic [15:0] mem [logic [14:0]];

  // Shared control between driver and the other processes
  logic [2:0]  snap = 3'd0;
  int          tb_hold = 0;
  int          fs_req = 0;
  logic [2:0]  fs_val = 3'd0;
  logic        inj_fs_hi = 1'b0;
  logic [2:0]  inj_fs_val = 3'd0;
  logic        inj_abort_hi = 1'b0;

  // Reference rule: tile = {attr[7:4], lo}; AA3 replaces the value modulo 8,
  // otherwise AA2 replaces it modulo 4, unless auto-animation is disabled.
  function automatic logic [19:0] model(input logic [15:0] lo, input logic [15:0] hi,
                                        input logic dis, input logic [2:0] s);
    int t;
    t = int'(hi[7:4]) * 65536 + int'(lo);
    if (!dis && hi[3])      t = t - (t % 8) + int'(s);
    else if (!dis && hi[2]) t = t - (t % 4) + (int'(s) % 4);
    return 20'(t);
  endfunction

  // VRAM responder plus event injector (FRAME_START, LINE_ABORT)
  initial begin : responder
    int wl;
    logic in_read;
    int fs_done;
    wl = 0; in_read = 1'b0; fs_done = 0;
    VRAM_ACK = 1'b0; VRAM_DATA = 16'h0; FRAME_START = 1'b0; AA_COUNT = 3'd0; LINE_ABORT = 1'b0;
    forever begin
      @(negedge CLK);
      FRAME_START = 1'b0;
      LINE_ABORT  = 1'b0;
      VRAM_ACK    = 1'b0;
      if (!RESETP) begin
        in_read = 1'b0;
        waitq.delete();
        addrq.delete();
      end else begin
        if (fs_done != fs_req) begin
          FRAME_START = 1'b1;
          AA_COUNT    = fs_val;
          fs_done     = fs_req;
        end
        if (VRAM_RD) begin
          if (!in_read) begin
            in_read = 1'b1;
            wl = (waitq.size() > 0) ? waitq.pop_front() : 0;
          end
          if (wl > 0) begin
            wl--;
          end else begin
            VRAM_ACK  = 1'b1;
            VRAM_DATA = mem.exists(VRAM_ADDR) ? mem[VRAM_ADDR] : 16'hDEAD;
            if (addrq.size() == 0) chk_fail("unexpected_vram_read");
            else chk("vram_addr", 32'(VRAM_ADDR), 32'(addrq.pop_front()));
            in_read = 1'b0;
            if (VRAM_ADDR[0]) begin
              if (inj_fs_hi) begin
                FRAME_START = 1'b1;
                AA_COUNT    = inj_fs_val;
              end
              if (inj_abort_hi) LINE_ABORT = 1'b1;
            end
          end
        end else begin
          in_read = 1'b0;
        end
      end
    end
  end

  // Monitor: compares each presented tile against the scoreboard head
  initial begin : monitor
    exp_t e;
    logic in_tile;
    logic handed;
    int hold;
    in_tile = 1'b0; handed = 1'b0; hold = 0;
    TILE_READY = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESETP) begin
        TILE_READY = 1'b0;
        in_tile = 1'b0;
        handed = 1'b0;
        sb.delete();
      end else begin
        if (handed) begin
          chk("valid_drop_after_ready", 32'(TILE_VALID), 32'd0);
          chk("busy_drop_after_ready", 32'(FETCH_BUSY), 32'd0);
          handed = 1'b0;
        end
        if (TILE_VALID) begin
          if (sb.size() == 0) begin
            chk_fail("unexpected_tile_valid");
            TILE_READY = 1'b1;
          end else begin
            e = sb[0];
            if (!in_tile) begin
              in_tile = 1'b1;
              chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
              hold = (tb_hold < 0) ? int'($urandom_range(0, 3)) : tb_hold;
            end
            chk("tile_num", 32'(TILE_NUM), 32'(e.num));
            chk("tile_pal", 32'(TILE_PAL), 32'(e.pal));
            chk("tile_hflip", 32'(TILE_HFLIP), 32'(e.hf));
            chk("tile_vflip", 32'(TILE_VFLIP), 32'(e.vf));
            chk("busy_while_valid", 32'(FETCH_BUSY), 32'd1);
            if (hold > 0) begin
              TILE_READY = 1'b0;
              hold--;
            end else begin
              TILE_READY = 1'b1;
              void'(sb.pop_front());
              in_tile = 1'b0;
              handed = 1'b1;
            end
          end
        end else begin
          TILE_READY = 1'b0;
          in_tile = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while ((FETCH_BUSY || TILE_VALID) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) chk_fail("idle_timeout");
  endtask

  task automatic set_snap(input logic [2:0] v);
    wait_idle();
    fs_val = v;
    fs_req++;
    repeat (2) @(negedge CLK);
    snap = v;
  endtask

  task automatic do_fetch(input logic [14:0] base, input logic [15:0] lo, input logic [15:0] hi,
                          input int w0, input int w1, input logic dis,
                          input logic fs_hi, input logic [2:0] fs_v,
                          input logic abort_hi, input logic extra_req);
    exp_t e;
    logic [14:0] a_lo;
    logic [14:0] a_hi;
    int n;
    wait_idle();
    a_lo = {base[14:1], 1'b0};
    a_hi = {base[14:1], 1'b1};
    mem[a_lo] = lo;
    mem[a_hi] = hi;
    waitq.push_back(w0);
    waitq.push_back(w1);
    addrq.push_back(a_lo);
    addrq.push_back(a_hi);
    AA_DISABLE   = dis;
    inj_fs_hi    = fs_hi;
    inj_fs_val   = fs_v;
    inj_abort_hi = abort_hi;
    e.num = model(lo, hi, dis, snap);
    e.pal = hi[15:8];
    e.hf  = hi[0];
    e.vf  = hi[1];
    e.lat = 3 + w0 + w1;
    FETCH_REQ = 1'b1;
    TILE_BASE = base;
    @(posedge CLK);
    #1;
    e.acc = cyc;
    chk("busy_after_accept", 32'(FETCH_BUSY), 32'd1);
    chk("vram_rd_after_accept", 32'(VRAM_RD), 32'd1);
    if (!abort_hi) sb.push_back(e);
    if (extra_req) begin
      TILE_BASE = 15'h7FFE;
      repeat (4) begin
        @(posedge CLK);
        #1;
      end
    end
    FETCH_REQ = 1'b0;
    if (fs_hi) snap = fs_v;
    if (abort_hi) begin
      n = 0;
      do begin
        @(posedge CLK);
        #1;
        n++;
      end while (!LINE_ABORT && n < 50);
      if (n >= 50) chk_fail("abort_timeout");
      chk("vram_rd_after_abort", 32'(VRAM_RD), 32'd0);
      chk("busy_after_abort", 32'(FETCH_BUSY), 32'd0);
      chk("valid_after_abort", 32'(TILE_VALID), 32'd0);
      repeat (6) @(negedge CLK);
    end
  endtask

  initial begin : driver
    int n;
    RESETP = 1'b0; AA_DISABLE = 1'b0; FETCH_REQ = 1'b0; TILE_BASE = 15'h0;
    repeat (3) @(negedge CLK);
    chk("rst_vram_rd", 32'(VRAM_RD), 32'd0);
    chk("rst_vram_addr", 32'(VRAM_ADDR), 32'd0);
    chk("rst_busy", 32'(FETCH_BUSY), 32'd0);
    chk("rst_valid", 32'(TILE_VALID), 32'd0);
    chk("rst_tile_num", 32'(TILE_NUM), 32'd0);
    chk("rst_tile_pal", 32'(TILE_PAL), 32'd0);
    chk("rst_hflip", 32'(TILE_HFLIP), 32'd0);
    chk("rst_vflip", 32'(TILE_VFLIP), 32'd0);
    RESETP = 1'b1;

    // Plain tile, zero-wait acks
    tb_hold = 0;
    do_fetch(15'h0040, 16'h1234, 16'h56F2, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Auto-animation modes with snapshot 5
    set_snap(3'd5);
    do_fetch(15'h0080, 16'hABC0, 16'h0008, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    do_fetch(15'h0080, 16'hABC0, 16'h0004, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    do_fetch(15'h0080, 16'hABC0, 16'h000C, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    do_fetch(15'h0080, 16'hABC0, 16'h0008, 0, 0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // Snapshot hazard: FRAME_START with 7 in the attribute ack cycle
    set_snap(3'd2);
    do_fetch(15'h0100, 16'h0000, 16'h0008, 0, 0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    do_fetch(15'h0100, 16'h0000, 16'h0008, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Wait states: two extra cycles on each read, odd base address
    do_fetch(15'h0101, 16'h2468, 16'h9A31, 2, 2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Backpressure with FETCH_REQ held while busy, then a normal follow-up
    tb_hold = 4;
    do_fetch(15'h0200, 16'h1111, 16'h2203, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    tb_hold = 0;
    do_fetch(15'h0300, 16'h3333, 16'h4401, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Abort coinciding with the attribute ack, then recovery
    do_fetch(15'h0400, 16'h5555, 16'h66F3, 0, 0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    do_fetch(15'h0500, 16'h7777, 16'h8802, 1, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Reset while a tile is presented
    tb_hold = 20;
    do_fetch(15'h0600, 16'h0010, 16'hFF08, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      #2;
      n++;
    end while (!TILE_VALID && n < 50);
    if (n >= 50) chk_fail("reset_test_valid_timeout");
    RESETP = 1'b0;
    #1;
    chk("arst_vram_rd", 32'(VRAM_RD), 32'd0);
    chk("arst_vram_addr", 32'(VRAM_ADDR), 32'd0);
    chk("arst_busy", 32'(FETCH_BUSY), 32'd0);
    chk("arst_valid", 32'(TILE_VALID), 32'd0);
    chk("arst_tile_num", 32'(TILE_NUM), 32'd0);
    chk("arst_tile_pal", 32'(TILE_PAL), 32'd0);
    chk("arst_hflip", 32'(TILE_HFLIP), 32'd0);
    chk("arst_vflip", 32'(TILE_VFLIP), 32'd0);
    snap = 3'd0;
    repeat (2) @(negedge CLK);
    #2;
    RESETP = 1'b1;
    tb_hold = 0;
    do_fetch(15'h0700, 16'h0007, 16'h0008, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Randomized traffic
    tb_hold = -1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) set_snap(3'($urandom_range(0, 7)));
      do_fetch(15'($urandom), 16'($urandom), 16'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
               3'($urandom_range(0, 7)), 1'b0, 1'b0);
    end

    wait_idle();
    repeat (4) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("reads_drained", 32'(addrq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
